dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the RV32I pipeline: the memory end of the MEM-stage ready/valid interface whose `o_dmem_ready`/`o_dmem_valid` outputs feed the hazard unit's stall logic.
- Accepts word-addressed load/store requests with byte write masks and holds a synchronous word array.
- Returns read data after a parameterized latency.
- Optionally clears the array after reset.
- Drops ready while busy, so the pipeline stalls instead of issuing into an occupied memory.

## Interface
- `DEPTH_WORDS`, default 1024, number of 32-bit words; power of two, ≥ 2.
- `LATENCY`, default 1, cycles from request accept to response; ≥ 1.
- `INIT_CLEAR`, default 1, 1 = zero every word after reset before accepting requests; 0 = go straight to IDLE.

Ports:
- `i_clk` in 1 — single clock; all state changes on the rising edge.
- `i_rst_n` in 1 — reset, asynchronous, active-low.
- `i_req_ren` in 1 — load request.
- `i_req_wen` in 1 — store request.
- `i_req_addr` in 32 — byte address. Bits [1:0] are ignored. The word index is bits [log2(DEPTH_WORDS)+1:2]; upper bits are ignored, so addresses alias.
- `i_req_wdata` in 32 — store data.
- `i_req_mask` in 4 — byte enables for the store; bit n writes byte n (bits [8n+7:8n]).
- `o_dmem_ready` out 1 — a request presented this cycle is accepted.
- `o_dmem_valid` out 1 — no transaction outstanding. When the last accepted request was a load, `o_rdata` holds its data.
- `o_rdata` out 32 — read word; holds its value until the next load completes.

## Operation
- States:
  - INIT: clear sweep.
  - IDLE: ready.
  - WAIT: latency count.
  - RESP: response cycle.
- Accept: occurs when `(i_req_ren | i_req_wen) & o_dmem_ready`.
  - Ren and wen both high is treated as a store only; `o_rdata` is unchanged.
  - A store with mask 0 is accepted and changes nothing.
- Stores commit to the array on the accept edge. Load data is sampled at the accept edge. A load issued the cycle after a store to the same word returns the new data.
- Outputs by state:
  - INIT: ready 0, valid 1. A write pointer runs from 0 to `DEPTH_WORDS`-1, zeroing one word per cycle. The cycle after the last word is cleared, the state moves to IDLE. Requests are ignored.
  - IDLE: ready 1, valid 1.
    - On accept with `LATENCY`=1, go to RESP.
    - On accept with `LATENCY`>1, go to WAIT and load the counter with `LATENCY`-2.
  - WAIT: ready 0, valid 0. Requests are ignored; the requester holds them via stall. The counter decrements to 0, then the state moves to RESP.
  - RESP: ready 1, valid 1, and `o_rdata` is updated if the completing transaction was a load.
    - An accept in RESP starts the next transaction exactly as from IDLE, so back-to-back requests are allowed.
    - Without an accept, go to IDLE.
- Counter width is clog2(`LATENCY`), minimum 1 bit.
- Reset (`i_rst_n` low), at any time including mid-WAIT:
  - Takes effect immediately: state goes to INIT (or IDLE if `INIT_CLEAR`=0), counter and pointer to 0, `o_rdata` to 0.
  - Outputs become ready 0 (1 if `INIT_CLEAR`=0), valid 1.
  - The array itself is not reset. A store accepted before reset remains written unless the INIT sweep clears it. A load in flight is discarded.

## Timing
- Reset values:
  - `o_dmem_ready` = 0 when `INIT_CLEAR`=1, else 1.
  - `o_dmem_valid` = 1.
  - `o_rdata` = 0.
- INIT lasts exactly `DEPTH_WORDS` cycles after `i_rst_n` rises. `o_dmem_ready` first goes high in cycle `DEPTH_WORDS` (counting the first post-reset edge as cycle 0).
- Accept at cycle T:
  - Response appears at cycle T+`LATENCY`.
  - `o_dmem_ready`/`o_dmem_valid` are low in cycles T+1 … T+`LATENCY`-1.
  - Both are high at T+`LATENCY`.
- Throughput is one transaction per `LATENCY` cycles. At `LATENCY`=1 the block accepts every cycle and valid never drops.
- Outputs are registered (state-decoded). There is no combinational path from request inputs to ready or valid.

## Test plan
- Init sweep, `DEPTH_WORDS`=16, `INIT_CLEAR`=1: release `i_rst_n`.
  - Ready must be 0 for cycles 0–15 and 1 at cycle 16.
  - A load of 0x24 must return 0x00000000.
- `LATENCY`=1: store 0xDEADBEEF, mask 4'hF, to 0x10, then load 0x10 the next cycle.
  - `o_rdata` = 0xDEADBEEF one cycle after the load is accepted.
  - Ready and valid stay 1 throughout.
- Byte mask: over 0xDEADBEEF at 0x10, store 0x11223344 with mask 4'b0101, then load 0x10.
  - Must return 0xDE22BE44.
- `LATENCY`=3: load 0x10 accepted at T, with the request held high.
  - Ready and valid must be 0 at T+1 and T+2.
  - At T+3 both must be 1 and `o_rdata` = 0xDEADBEEF.
  - Exactly one accept occurs.
- Aliasing and dual request, `DEPTH_WORDS`=16:
  - Store 0xCAFEF00D to 0x40 with ren=wen=1; `o_rdata` must be unchanged.
  - Then load 0x00; it must return 0xCAFEF00D.
- Reset mid-WAIT, `LATENCY`=3, `INIT_CLEAR`=0: store 0xA5A5A5A5 to 0x8, then start a load and drop `i_rst_n` at T+1.
  - Immediately: ready 1, valid 1, `o_rdata` 0.
  - After release, a load of 0x8 returns 0xA5A5A5A5.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory with byte-masked stores and fixed-latency ready/valid responses
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1,
    parameter bit INIT_CLEAR  = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_ren,
    input  logic        i_req_wen,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_mask,
    output logic        o_dmem_ready,
    output logic        o_dmem_valid,
    output logic [31:0] o_rdata
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 1) ? LATENCY - 2 : 0);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH_WORDS - 1);

    typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] ptr;
    logic [AW-1:0] idx;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0]   rd_buf;
    logic          pend_load;
    logic          acc;
    logic          acc_load;
    logic          unused_addr;

    assign idx          = i_req_addr[AW+1:2];
    assign unused_addr  = ^{i_req_addr[31:AW+2], i_req_addr[1:0]};
    assign o_dmem_ready = (state == IDLE) || (state == RESP);
    assign o_dmem_valid = (state != WAIT);
    assign acc          = (i_req_ren | i_req_wen) & o_dmem_ready;
    assign acc_load     = acc & i_req_ren & ~i_req_wen;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (acc) begin
            state_nxt = (LATENCY == 1) ? RESP : WAIT;
            cnt_nxt   = CNT_LOAD;
        end else if (state == INIT) begin
            state_nxt = (ptr == LAST_PTR) ? IDLE : INIT;
        end else if (state == WAIT) begin
            state_nxt = (cnt == '0) ? RESP : WAIT;
            cnt_nxt   = (cnt == '0) ? cnt : cnt - 1'b1;
        end else if (state == RESP) begin
            state_nxt = IDLE;
        end
    end

    // Load data is captured at accept; it reaches o_rdata on the edge that enters RESP
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= INIT_CLEAR ? INIT : IDLE;
            cnt       <= '0;
            ptr       <= '0;
            pend_load <= 1'b0;
            rd_buf    <= '0;
            o_rdata   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ptr   <= (state == INIT) ? ptr + 1'b1 : ptr;
            if (acc) begin
                pend_load <= acc_load;
                rd_buf    <= mem[idx];
            end
            if (state_nxt == RESP && (acc ? acc_load : pend_load))
                o_rdata <= acc ? mem[idx] : rd_buf;
        end
    end

    // The array has no reset; writes are blocked while reset is held
    always_ff @(posedge i_clk) begin
        if (i_rst_n && state == INIT)
            mem[ptr] <= '0;
        else if (i_rst_n && acc && i_req_wen)
            for (int b = 0; b < 4; b++)
                if (i_req_mask[b])
                    mem[idx][8*b +: 8] <= i_req_wdata[8*b +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven and hand-sequenced checks of dmem_responder at LATENCY 1 and 3
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1_n, ren1, wen1, rdy1, vld1;
    logic [31:0] addr1, wdata1, rd1;
    logic [3:0]  mask1;
    logic        rst3_n, ren3, wen3, rdy3, vld3;
    logic [31:0] addr3, wdata3, rd3;
    logic [3:0]  mask3;

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1), .INIT_CLEAR(1'b1)) u1 (
        .i_clk(clk), .i_rst_n(rst1_n), .i_req_ren(ren1), .i_req_wen(wen1),
        .i_req_addr(addr1), .i_req_wdata(wdata1), .i_req_mask(mask1),
        .o_dmem_ready(rdy1), .o_dmem_valid(vld1), .o_rdata(rd1)
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(3), .INIT_CLEAR(1'b0)) u3 (
        .i_clk(clk), .i_rst_n(rst3_n), .i_req_ren(ren3), .i_req_wen(wen3),
        .i_req_addr(addr3), .i_req_wdata(wdata3), .i_req_mask(mask3),
        .o_dmem_ready(rdy3), .o_dmem_valid(vld3), .o_rdata(rd3)
    );

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp;
    } vec_t;

    vec_t        v[11];
    logic [31:0] sbq[$];
    logic [31:0] last_rd;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          acc3  = 0;

    always @(posedge clk)
        if (rst3_n && (ren3 || wen3) && rdy3) acc3++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic sweep1(input string tag);
        int low;
        ren1 = 1'b0;
        wen1 = 1'b0;
        @(negedge clk);
        rst1_n = 1'b0;
        @(negedge clk);
        check({tag, "_rst_ready"}, 32'(rdy1), 32'd0);
        check({tag, "_rst_valid"}, 32'(vld1), 32'd1);
        check({tag, "_rst_rdata"}, rd1, 32'd0);
        rst1_n = 1'b1;
        low = 0;
        #1;
        for (int k = 0; k < 16; k++) begin
            if (rdy1 === 1'b0 && vld1 === 1'b1) low++;
            @(negedge clk);
        end
        check({tag, "_init_low_cycles"}, 32'(low), 32'd16);
        check({tag, "_ready_c16"}, 32'(rdy1), 32'd1);
    endtask

    task automatic txn3(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic [31:0] exp, input string tag);
        int  a0;
        int  n;
        logic ld;
        ld = r && !w;
        n  = 0;
        while (rdy3 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (rdy3 !== 1'b1) begin
            check({tag, "_ready_timeout"}, 32'(rdy3), 32'd1);
            return;
        end
        a0    = acc3;
        ren3  = r;
        wen3  = w;
        addr3 = a;
        wdata3 = d;
        mask3 = m;
        if (ld) sbq.push_back(exp);
        @(negedge clk);
        check({tag, "_t1_ready"}, 32'(rdy3), 32'd0);
        check({tag, "_t1_valid"}, 32'(vld3), 32'd0);
        @(negedge clk);
        check({tag, "_t2_ready"}, 32'(rdy3), 32'd0);
        check({tag, "_t2_valid"}, 32'(vld3), 32'd0);
        @(negedge clk);
        check({tag, "_t3_ready"}, 32'(rdy3), 32'd1);
        check({tag, "_t3_valid"}, 32'(vld3), 32'd1);
        if (ld) begin
            last_rd = sbq.pop_front();
            check({tag, "_t3_rdata"}, rd3, last_rd);
        end else begin
            check({tag, "_t3_rdata_hold"}, rd3, last_rd);
        end
        check({tag, "_accepts"}, 32'(acc3 - a0), 32'd1);
        ren3 = 1'b0;
        wen3 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst1_n = 1'b0; ren1 = 1'b0; wen1 = 1'b0; addr1 = '0; wdata1 = '0; mask1 = '0;
        rst3_n = 1'b0; ren3 = 1'b0; wen3 = 1'b0; addr3 = '0; wdata3 = '0; mask3 = '0;

        v[0]  = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0};
        v[1]  = '{1'b1, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF};
        v[2]  = '{1'b0, 1'b1, 32'h10, 32'h11223344, 4'h5, 32'h0};
        v[3]  = '{1'b1, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDE22BE44};
        v[4]  = '{1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0};
        v[5]  = '{1'b1, 1'b0, 32'h00, 32'h0,        4'h0, 32'hCAFEF00D};
        v[6]  = '{1'b0, 1'b1, 32'h3C, 32'hFFFFFFFF, 4'h0, 32'h0};
        v[7]  = '{1'b1, 1'b0, 32'h3C, 32'h0,        4'h0, 32'h0};
        v[8]  = '{1'b1, 1'b0, 32'h24, 32'h0,        4'h0, 32'h0};
        v[9]  = '{1'b0, 1'b1, 32'h07, 32'h55667788, 4'hA, 32'h0};
        v[10] = '{1'b1, 1'b0, 32'h04, 32'h0,        4'h0, 32'h55007700};

        sweep1("sweep_a");
        ren1 = 1'b0; wen1 = 1'b1; addr1 = 32'h24; wdata1 = 32'h12345678; mask1 = 4'hF;
        @(negedge clk);
        ren1 = 1'b1; wen1 = 1'b0;
        @(negedge clk);
        check("dirty_word9", rd1, 32'h12345678);
        sweep1("sweep_b");

        last_rd = 32'h0;
        for (int i = 0; i < 11; i++) begin
            ren1 = v[i].ren; wen1 = v[i].wen; addr1 = v[i].addr; wdata1 = v[i].wdata; mask1 = v[i].mask;
            if (v[i].ren && !v[i].wen) sbq.push_back(v[i].exp);
            @(negedge clk);
            check($sformatf("v%0d_ready", i), 32'(rdy1), 32'd1);
            check($sformatf("v%0d_valid", i), 32'(vld1), 32'd1);
            if (v[i].ren && !v[i].wen) begin
                last_rd = sbq.pop_front();
                check($sformatf("v%0d_rdata", i), rd1, last_rd);
            end else begin
                check($sformatf("v%0d_rdata_hold", i), rd1, last_rd);
            end
        end
        ren1 = 1'b0; wen1 = 1'b0;

        @(negedge clk);
        check("u3_rst_ready", 32'(rdy3), 32'd1);
        check("u3_rst_valid", 32'(vld3), 32'd1);
        check("u3_rst_rdata", rd3, 32'd0);
        rst3_n = 1'b1;
        last_rd = 32'h0;
        @(negedge clk);
        txn3(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, "l3_store");
        @(negedge clk);
        txn3(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, "l3_load");
        @(negedge clk);
        check("l3_idle_ready", 32'(rdy3), 32'd1);
        txn3(1'b0, 1'b1, 32'h08, 32'hA5A5A5A5, 4'hF, 32'h0, "l3_store8");
        @(negedge clk);

        ren3 = 1'b1; wen3 = 1'b0; addr3 = 32'h08;
        @(negedge clk);
        rst3_n = 1'b0;
        #1;
        check("midwait_rst_ready", 32'(rdy3), 32'd1);
        check("midwait_rst_valid", 32'(vld3), 32'd1);
        check("midwait_rst_rdata", rd3, 32'd0);
        ren3 = 1'b0;
        @(negedge clk);
        rst3_n = 1'b1;
        last_rd = 32'h0;
        @(negedge clk);
        check("post_rst_discard", rd3, 32'd0);
        check("post_rst_ready", 32'(rdy3), 32'd1);
        txn3(1'b1, 1'b0, 32'h08, 32'h0, 4'h0, 32'hA5A5A5A5, "post_rst_load");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
